// File: rtl/dm_cache_if.sv
// CPU read port and main-memory block port of the direct-mapped cache controller.
// master = requester/memory side, slave = cache controller.
interface dm_cache_if #(
    parameter int ADDR_W = 15
);
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_addr;
    logic              flush;
    logic [31:0]       cpu_data;
    logic              cpu_ready;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_data0;
    logic [31:0]       mem_data1;
    logic [31:0]       mem_data2;
    logic [31:0]       mem_data3;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    modport master (
        output cpu_rd, cpu_addr, flush, mem_data0, mem_data1, mem_data2, mem_data3,
        input  cpu_data, cpu_ready, busy, mem_addr, mem_rd, hit_count, miss_count
    );

    modport slave (
        input  cpu_rd, cpu_addr, flush, mem_data0, mem_data1, mem_data2, mem_data3,
        output cpu_data, cpu_ready, busy, mem_addr, mem_rd, hit_count, miss_count
    );
endinterface

// File: rtl/dm_cache_controller.sv
// Read-only direct-mapped cache in front of a combinational 4-word-block main memory.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache_controller #(
    parameter int ADDR_W       = 15,
    parameter int INDEX_W      = 8,
    parameter int MISS_PENALTY = 4
) (
    input logic          clk,
    input logic          rst,
    dm_cache_if.slave    bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int NBLK  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, CHECK, MEM_WAIT, FILL, RESPOND} state_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [1:0]         off;
    } req_t;

    state_t           state;
    req_t             req;
    logic [NBLK-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [NBLK];
    logic [3:0][31:0] data_arr [NBLK];
    logic [7:0]       wait_cnt;
    logic [31:0]      cpu_data;
    logic             cpu_ready;
    logic             busy;
    logic [ADDR_W-1:0] mem_addr;
    logic             mem_rd;
    logic [3:0][31:0] mem_blk;
    logic             hit;

    assign mem_blk = {bus.mem_data3, bus.mem_data2, bus.mem_data1, bus.mem_data0};
    assign hit     = valid[req.index] && (tag_arr[req.index] == req.tag);

    assign bus.cpu_data  = cpu_data;
    assign bus.cpu_ready = cpu_ready;
    assign bus.busy      = busy;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_rd    = mem_rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            cpu_data  <= '0;
            cpu_ready <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.cpu_rd) begin
                        req   <= req_t'(bus.cpu_addr);
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        cpu_data  <= data_arr[req.index][req.off];
                        cpu_ready <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        mem_addr <= {req.tag, req.index, 2'b00};
                        mem_rd   <= 1'b1;
                        wait_cnt <= 8'(MISS_PENALTY - 1);
                        state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // mem_rd drops on the way out so it is high for exactly MISS_PENALTY cycles
                    if (wait_cnt == 8'd0) begin
                        mem_rd <= 1'b0;
                        state  <= FILL;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                FILL: begin
                    valid[req.index] <= 1'b1;
                    cpu_data         <= mem_blk[req.off];
                    cpu_ready        <= 1'b1;
                    state            <= RESPOND;
                end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage has no reset; a reset landing on FILL must not commit the block.
    always_ff @(posedge clk) begin
        if (rst && state == FILL) begin
            tag_arr[req.index]  <= req.tag;
            data_arr[req.index] <= mem_blk;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == CHECK) begin
            if (hit && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (!hit && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller: table of reads plus flush/reset corner sequences.
module tb_dm_cache_controller;
    localparam int P = 4;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_cache_if #(.ADDR_W(15)) bus ();

    dm_cache_controller #(.ADDR_W(15), .INDEX_W(8), .MISS_PENALTY(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Main memory model: each word holds its own word address.
    assign bus.mem_data0 = {17'b0, bus.mem_addr[14:2], 2'd0};
    assign bus.mem_data1 = {17'b0, bus.mem_addr[14:2], 2'd1};
    assign bus.mem_data2 = {17'b0, bus.mem_addr[14:2], 2'd2};
    assign bus.mem_data3 = {17'b0, bus.mem_addr[14:2], 2'd3};

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every cpu_ready pulse must match the oldest pending read.
    always @(negedge clk) begin
        if (rst && bus.cpu_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_ready: got unexpected pulse, data %h", bus.cpu_data);
            end else begin
                chk("cpu_data", bus.cpu_data, sb_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
    task automatic do_read(input logic [14:0] addr, input bit exp_hit, input bit flush_mid);
        int  lat;
        int  mrd;
        bit  done;
        lat  = 0;
        mrd  = 0;
        done = 1'b0;
        sb_q.push_back({17'b0, addr});
        bus.cpu_addr = addr;
        bus.cpu_rd   = 1'b1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.mem_rd === 1'b1) begin
                mrd++;
                chk("mem_addr", 32'(bus.mem_addr), 32'({addr[14:2], 2'b00}));
            end
            bus.flush = (flush_mid && lat == 3);
            if (bus.cpu_ready === 1'b1) done = 1'b1;
        end
        bus.cpu_rd = 1'b0;
        bus.flush  = 1'b0;
        chk("latency", 32'(lat), exp_hit ? 32'd2 : 32'(3 + P));
        chk("mem_rd_cycles", 32'(mrd), exp_hit ? 32'd0 : 32'(P));
        @(negedge clk);
        chk("busy_after", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic [14:0] addr;
        bit          flush_first;
        bit          flush_mid;
        bit          exp_hit;
    } vec_t;

    vec_t vecs[12];
    int   rdy_seen;

    initial begin
        vecs[0]  = '{15'h0005, 1'b0, 1'b0, 1'b0};  // cold miss
        vecs[1]  = '{15'h0006, 1'b0, 1'b0, 1'b1};  // same block hit
        vecs[2]  = '{15'h0405, 1'b0, 1'b0, 1'b0};  // conflict, tag 1
        vecs[3]  = '{15'h0005, 1'b0, 1'b0, 1'b0};  // evicted, miss again
        vecs[4]  = '{15'h0006, 1'b1, 1'b0, 1'b0};  // flushed -> miss
        vecs[5]  = '{15'h0007, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{15'h0005, 1'b1, 1'b1, 1'b0};  // flush during MEM_WAIT ignored
        vecs[7]  = '{15'h0005, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{15'h1234, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{15'h1237, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{15'h7FFF, 1'b0, 1'b0, 1'b0};  // top index, max tag
        vecs[11] = '{15'h7FFC, 1'b0, 1'b0, 1'b1};

        bus.cpu_rd   = 1'b0;
        bus.cpu_addr = '0;
        bus.flush    = 1'b0;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_cpu_data", bus.cpu_data, 32'd0);
        chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
        chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].flush_first) begin
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
            do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].flush_mid);
            if (i == 3) begin
                chk("hit_count", 32'(bus.hit_count), STATS ? 32'd1 : 32'd0);
                chk("miss_count", 32'(bus.miss_count), STATS ? 32'd3 : 32'd0);
            end
        end

        // Reset while waiting on memory: request is dropped, nothing is filled.
        bus.cpu_addr = 15'h2001;
        bus.cpu_rd   = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_rd", 32'(bus.mem_rd), 32'd1);
        rst        = 1'b0;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("abort_cpu_data", bus.cpu_data, 32'd0);
        rst      = 1'b1;
        rdy_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) rdy_seen++;
        end
        chk("abort_no_ready", 32'(rdy_seen), 32'd0);
        do_read(15'h2001, 1'b0, 1'b0);
        chk("post_rst_hit_count", 32'(bus.hit_count), 32'd0);
        chk("post_rst_miss_count", 32'(bus.miss_count), STATS ? 32'd1 : 32'd0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_cache_controller.md
Name: dm_cache_controller

Overview:
Read-only direct-mapped cache controller between a single CPU read port and the 32K-word main memory block, which returns a 4-word block combinationally for a 15-bit word address.
- Holds tag, valid and data arrays internally.
- Sequences hit/miss handling and the memory-wait penalty.
- Performs the block fill and returns the requested word with a one-cycle ready pulse.

Parameters:
ADDR_W, 15, word address width (matches main memory)
INDEX_W, 8, index bits; 2^INDEX_W blocks of 4 words (default 1024 words cached); tag width = ADDR_W-INDEX_W-2
MISS_PENALTY, 4, cycles spent in MEM_WAIT per miss; legal range 1..255

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
cpu_rd  input  1  read request level; requester holds cpu_addr stable until cpu_ready
cpu_addr  input  ADDR_W  word address: [1:0] offset, [INDEX_W+1:2] index, [ADDR_W-1:INDEX_W+2] tag
flush  input  1  invalidate all blocks; honoured only in IDLE
cpu_data  output  32  requested word, valid while cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse
busy  output  1  high in every state except IDLE
mem_addr  output  ADDR_W  block address to main memory, {tag,index,2'b00}
mem_rd  output  1  high during MEM_WAIT
mem_data0..mem_data3  input  32 each  words 0..3 of the addressed block from main memory
hit_count  output  16  see Optional Feature
miss_count  output  16  see Optional Feature

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; all valid bits cleared; cpu_data=0, cpu_ready=0, mem_addr=0, mem_rd=0, counters=0.
  - Tag/data arrays are not cleared.
  - Reset mid-operation aborts: no fill, no cpu_ready.
- State machine, all outputs registered:
  - IDLE: flush=1 -> clear all valid bits, stay IDLE, cpu_rd ignored that cycle (flush wins). Else cpu_rd=1 -> latch cpu_addr, go CHECK.
  - CHECK: hit = valid[index] && tag_arr[index]==tag.
    - Hit -> load cpu_data from data_arr[index][offset], go RESPOND.
    - Miss -> mem_addr={tag,index,00}, mem_rd=1, wait counter=MISS_PENALTY-1, go MEM_WAIT.
  - MEM_WAIT: counter decrements each cycle; at 0 go FILL. Occupies exactly MISS_PENALTY cycles.
  - FILL:
    - Capture mem_data0..3 into data_arr[index] and write tag_arr[index].
    - Set valid[index]=1 and mem_rd=0.
    - cpu_data = mem_data[offset]; go RESPOND.
  - RESPOND: cpu_ready=1 for exactly this cycle; go IDLE.
- Latency (request first seen in IDLE in cycle k):
  - Hit: cpu_ready in cycle k+2.
  - Miss: cpu_ready in cycle k+3+MISS_PENALTY.
- The requester must drop cpu_rd (or present a new address) by the edge ending the cpu_ready cycle. A cpu_rd still high in the following IDLE cycle is a new request.
- flush outside IDLE is ignored (not queued).
- Conflict miss (same index, different tag) overwrites the block; no writeback (read-only).
- mem_addr holds its last value outside MEM_WAIT/FILL.

Optional Feature:
CACHE_STATS_EN
- Defined: hit_count increments on each CHECK hit, miss_count on each CHECK miss. Both 16-bit, saturate at 0xFFFF, cleared by reset. flush does not clear them.
- Undefined: both outputs constant 0; no counter flops.

Test Plan:
Test memory model returns word = {17'b0, address}; MISS_PENALTY=4.
1. Reset, then cpu_rd with cpu_addr=0x0005 -> miss; mem_rd high 4 cycles with mem_addr=0x0004; cpu_ready in cycle k+7 with cpu_data=0x00000005.
2. Then cpu_addr=0x0006 -> hit; cpu_ready at k+2, cpu_data=0x00000006, mem_rd stays 0.
3. cpu_addr=0x0405 (same index 1, tag 1) -> miss, data 0x00000405; then 0x0005 -> miss again, data 0x00000005.
4. flush pulse in IDLE, then 0x0006 -> miss. flush asserted during MEM_WAIT -> ignored, following re-read of the same address hits.
5. rst=0 during MEM_WAIT -> cpu_ready never pulses, busy=0 next cycle; re-read same address -> miss.
6. With CACHE_STATS_EN defined, run steps 1-3 -> hit_count=1, miss_count=3. Without it, both read 0.
